// File: rtl/neuron_core_pipe.sv
// Event-driven integrate-and-fire neuron core with a one-stage update pipeline,
// a single-entry spike output slot and a background leak sweep.
module neuron_core_pipe #(
  parameter int N  = 256,
  parameter int M  = 8,
  parameter int VW = 8,
  parameter int WW = 4
) (
  input  logic          CLK,
  input  logic          RSTN_syncn,
  input  logic [VW-1:0] CFG_THR,
  input  logic [VW-1:0] CFG_LEAK,
  input  logic          CFG_LEAK_EN,
  input  logic          EV_VALID,
  output logic          EV_READY,
  input  logic [M-1:0]  EV_ADDR,
  input  logic [WW-1:0] EV_WEIGHT,
  input  logic          EV_SIGN,
  input  logic          LEAK_START,
  output logic          LEAK_BUSY,
  input  logic          PROG_WE,
  input  logic [M-1:0]  PROG_ADDR,
  input  logic [VW-1:0] PROG_DATA,
  output logic          SPK_VALID,
  input  logic          SPK_READY,
  output logic [M-1:0]  SPK_ADDR,
  output logic [15:0]   SPK_CNT,
  output logic [VW-1:0] MON_V
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state_q, state_d;
  logic          leak_pend_q, leak_pend_d;
  logic          pipe_vld_q, pipe_vld_d;
  logic [M-1:0]  pipe_addr_q, pipe_addr_d;
  logic [WW-1:0] pipe_wt_q, pipe_wt_d;
  logic          pipe_sign_q, pipe_sign_d;
  logic [M-1:0]  sweep_addr_q, sweep_addr_d;
  logic          spk_vld_q, spk_vld_d;
  logic [M-1:0]  spk_addr_q, spk_addr_d;
  logic [15:0]   spk_cnt_q, spk_cnt_d;
  logic [VW-1:0] mon_v_q, mon_v_d;
  logic [VW-1:0] mem_q [N];
  logic [VW-1:0] mem_d [N];

  logic          ev_accept, prog_ok, fire, wr_en;
  logic [VW:0]   ext_v, ext_w, sum_v, dif_v;
  logic [VW-1:0] cur_v, new_v, lk_v, leak_v, wr_data;
  logic [M-1:0]  wr_addr;

  assign EV_READY  = (state_q == IDLE) && !leak_pend_q && !PROG_WE && (!spk_vld_q || SPK_READY);
  assign LEAK_BUSY = leak_pend_q || (state_q == SWEEP);
  assign SPK_VALID = spk_vld_q;
  assign SPK_ADDR  = spk_addr_q;
  assign SPK_CNT   = spk_cnt_q;
  assign MON_V     = mon_v_q;

  assign ev_accept = EV_VALID && EV_READY;
  assign prog_ok   = PROG_WE && (state_q == IDLE) && !pipe_vld_q;

  // The stage reads the array one edge after the previous write, so a
  // back-to-back event to the same neuron always sees the freshly written value.
  always_comb begin
    cur_v  = mem_q[pipe_addr_q];
    ext_v  = {1'b0, cur_v};
    ext_w  = (VW+1)'(pipe_wt_q);
    sum_v  = ext_v + ext_w;
    dif_v  = ext_v - ext_w;
    new_v  = '0;
    if (pipe_sign_q) new_v = dif_v[VW] ? '0 : dif_v[VW-1:0];
    else             new_v = sum_v[VW] ? '1 : sum_v[VW-1:0];
    fire   = (CFG_THR != '0) && (new_v >= CFG_THR);
    lk_v   = mem_q[sweep_addr_q];
    leak_v = (lk_v > CFG_LEAK) ? (lk_v - CFG_LEAK) : '0;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == SWEEP) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr_q;
      wr_data = leak_v;
    end else if (pipe_vld_q) begin
      wr_en   = 1'b1;
      wr_addr = pipe_addr_q;
      wr_data = fire ? '0 : new_v;
    end else if (prog_ok) begin
      wr_en   = 1'b1;
      wr_addr = PROG_ADDR;
      wr_data = PROG_DATA;
    end
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    mon_v_d = wr_en ? wr_data : mon_v_q;
  end

  always_comb begin
    pipe_vld_d  = ev_accept;
    pipe_addr_d = ev_accept ? EV_ADDR : pipe_addr_q;
    pipe_wt_d   = ev_accept ? EV_WEIGHT : pipe_wt_q;
    pipe_sign_d = ev_accept ? EV_SIGN : pipe_sign_q;
    spk_vld_d   = spk_vld_q && !SPK_READY;
    spk_addr_d  = spk_addr_q;
    spk_cnt_d   = spk_cnt_q;
    if (pipe_vld_q && fire) begin
      spk_vld_d  = 1'b1;
      spk_addr_d = pipe_addr_q;
      if (spk_cnt_q != 16'hFFFF) spk_cnt_d = spk_cnt_q + 16'd1;
    end
  end

  // Programming outranks a pending sweep; the sweep waits for the stage to drain.
  always_comb begin
    state_d      = state_q;
    leak_pend_d  = leak_pend_q;
    sweep_addr_d = sweep_addr_q;
    if (LEAK_START && CFG_LEAK_EN && !LEAK_BUSY) leak_pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (!prog_ok && leak_pend_q && !pipe_vld_q) begin
          state_d      = SWEEP;
          leak_pend_d  = 1'b0;
          sweep_addr_d = '0;
        end
      end
      SWEEP: begin
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (sweep_addr_q == M'(N-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN_syncn) begin
    if (!RSTN_syncn) begin
      state_q      <= IDLE;
      leak_pend_q  <= 1'b0;
      pipe_vld_q   <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_wt_q    <= '0;
      pipe_sign_q  <= 1'b0;
      sweep_addr_q <= '0;
      spk_vld_q    <= 1'b0;
      spk_addr_q   <= '0;
      spk_cnt_q    <= '0;
      mon_v_q      <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      leak_pend_q  <= leak_pend_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_wt_q    <= pipe_wt_d;
      pipe_sign_q  <= pipe_sign_d;
      sweep_addr_q <= sweep_addr_d;
      spk_vld_q    <= spk_vld_d;
      spk_addr_q   <= spk_addr_d;
      spk_cnt_q    <= spk_cnt_d;
      mon_v_q      <= mon_v_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: doc/neuron_core_pipe.md
NEURON_CORE_PIPE -- requirements
Module: neuron_core_pipe

Interface
REQ-001 SHALL have parameter N, default 256: number of neurons.
REQ-002 SHALL have parameter M, default 8: neuron address width, log2(N).
REQ-003 SHALL have parameter VW, default 8: membrane potential width.
REQ-004 SHALL have parameter WW, default 4: synaptic weight width.
REQ-005 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RSTN_syncn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port CFG_THR, input, VW: firing threshold, global.
REQ-008 SHALL have port CFG_LEAK, input, VW: leak amount per sweep.
REQ-009 SHALL have port CFG_LEAK_EN, input, 1: enables leak sweeps.
REQ-010 SHALL have port EV_VALID, input, 1: synaptic event offered.
REQ-011 SHALL have port EV_READY, output, 1: event accepted when EV_VALID and EV_READY are both high at a rising edge.
REQ-012 SHALL have port EV_ADDR, input, M: target neuron.
REQ-013 SHALL have port EV_WEIGHT, input, WW: unsigned weight magnitude.
REQ-014 SHALL have port EV_SIGN, input, 1: 1 = inhibitory, 0 = excitatory.
REQ-015 SHALL have port LEAK_START, input, 1: leak sweep request pulse.
REQ-016 SHALL have port LEAK_BUSY, output, 1: sweep pending or running.
REQ-017 SHALL have ports PROG_WE (input, 1), PROG_ADDR (input, M) and PROG_DATA (input, VW): direct membrane write.
REQ-018 SHALL have port SPK_VALID, output, 1: spike pending in the output slot.
REQ-019 SHALL have port SPK_READY, input, 1: consumer accepts the spike.
REQ-020 SHALL have port SPK_ADDR, output, M: address of the spiking neuron.
REQ-021 SHALL have port SPK_CNT, output, 16: saturating count of spikes issued.
REQ-022 SHALL have port MON_V, output, VW: post-update membrane value of the last neuron written.

Function
REQ-023 SHALL hold an internal N x VW membrane array, with an FSM of two states: IDLE and SWEEP.
REQ-024 SHALL drive EV_READY = (state==IDLE) && !leak_pending && !PROG_WE && (!SPK_VALID || SPK_READY).
REQ-025 SHALL, on event accept in cycle t, register the event into a pipeline stage; the stage-2 update writes the array and loads the spike slot at edge t+1 (latency 1 cycle).
REQ-026 SHALL, for an excitatory event, compute v' = min(v + EV_WEIGHT, 2^VW-1), in VW+1-bit arithmetic.
REQ-027 SHALL, for an inhibitory event, compute v' = max(v - EV_WEIGHT, 0).
REQ-028 SHALL, when v' >= CFG_THR and CFG_THR != 0, write 0 to the neuron, set SPK_VALID, load SPK_ADDR, and increment SPK_CNT (saturating at 0xFFFF).
REQ-029 SHALL, when CFG_THR == 0, never issue spikes.
REQ-030 SHALL, for back-to-back events to the same address, make the second event use the first event's written result: forwarding from stage 2, with no lost update.
REQ-031 SHALL clear SPK_VALID when SPK_VALID && SPK_READY and no new spike is loaded; a simultaneous drain and load keeps SPK_VALID high with the new address.
REQ-032 SHALL, on LEAK_START with CFG_LEAK_EN=1, set leak_pending; the pulse is ignored if already busy or if CFG_LEAK_EN=0.
REQ-033 SHALL, in IDLE with leak_pending set and the pipeline stage empty, go to SWEEP and clear pending.
REQ-034 SHALL, in SWEEP, update one neuron per cycle, addresses 0..N-1: v' = max(v - CFG_LEAK, 0); sweeps never spike; after address N-1, return to IDLE.
REQ-035 SHALL drive LEAK_BUSY = leak_pending || state==SWEEP.
REQ-036 SHALL honour PROG_WE only in IDLE with the pipeline stage empty, writing PROG_DATA at the edge; otherwise PROG_WE is ignored.
REQ-037 SHALL have the following priority in IDLE: PROG_WE, then pending sweep, then events.
REQ-038 SHALL update MON_V on every array write: event, sweep or program.

Reset
REQ-039 SHALL, while RSTN_syncn is low, clear all membranes to 0, force the FSM to IDLE, and clear leak_pending, the pipeline valid, SPK_VALID, SPK_ADDR, SPK_CNT and MON_V to 0; EV_READY=1 and LEAK_BUSY=0 after reset.
REQ-040 SHALL, on reset asserted mid-sweep or mid-event, abort the operation immediately; no partial write survives.

Verification
REQ-041 SHALL cover accumulation: CFG_THR=20; five excitatory events, weight 4, to neuron 7 back-to-back -> the 5th produces SPK_VALID with SPK_ADDR=7, neuron 7 reads 0, SPK_CNT=1.
REQ-042 SHALL cover saturation and floor: PROG neuron 3=250 with CFG_THR=0, excitatory weight 15 -> MON_V=255; then PROG neuron 3=5, inhibitory weight 9 -> MON_V=0.
REQ-043 SHALL cover back-pressure: spike pending with SPK_READY=0 -> EV_READY=0 until SPK_READY=1, with no event lost or duplicated.
REQ-044 SHALL cover the sweep: neurons 0..255 programmed to 10, CFG_LEAK=3, LEAK_START -> LEAK_BUSY high for 1+256 cycles, all neurons read 7, no spikes.
REQ-045 SHALL cover simultaneous requests: LEAK_START and EV_VALID in the same IDLE cycle -> the event is accepted, the sweep starts after the pipeline empties, and EV_READY=0 during the sweep.
REQ-046 SHALL cover reset mid-sweep: reset at address 100 -> all state returns to 0, LEAK_BUSY=0, and a fresh event then works normally.
